// File: rtl/adrdec_fsm.sv
// Single-master address decoder: routes one request at a time to the slave whose
// masked base matches, waits for that slave's ack (with optional timeout) and returns a one-cycle response.
module adrdec_fsm #(
  parameter int                     NSLAVES = 4,
  parameter int                     AW      = 8,
  parameter int                     DW      = 8,
  parameter logic [NSLAVES*AW-1:0]  BASE    = {8'h30, 8'h20, 8'h10, 8'h00},
  parameter logic [NSLAVES*AW-1:0]  MASK    = {4{8'hF0}},
  parameter int                     TMO     = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m_req,
  input  logic                  m_we,
  input  logic [AW-1:0]         m_adr,
  input  logic [DW-1:0]         m_wdat,
  output logic                  m_ack,
  output logic                  m_err,
  output logic [DW-1:0]         m_rdat,
  output logic [NSLAVES-1:0]    s_sel,
  output logic                  s_we,
  output logic [AW-1:0]         s_adr,
  output logic [DW-1:0]         s_wdat,
  input  logic [NSLAVES-1:0]    s_ack,
  input  logic [NSLAVES*DW-1:0] s_rdat
);

  localparam int CW = (TMO > 0) ? $clog2(TMO + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t               state_q, state_d;
  logic [NSLAVES-1:0]   sel_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [DW-1:0]        rdat_q, rdat_d;
  logic                 load;

  logic                 hit;
  logic [NSLAVES-1:0]   dec_oh;
  logic [DW-1:0]        rdat_sel;
  logic                 ack_sel;

  // Descending scan so the lowest matching slave is the last one written and wins.
  always_comb begin
    hit    = 1'b0;
    dec_oh = '0;
    for (int k = NSLAVES - 1; k >= 0; k--) begin
      if ((m_adr & MASK[k*AW +: AW]) == (BASE[k*AW +: AW] & MASK[k*AW +: AW])) begin
        hit       = 1'b1;
        dec_oh    = '0;
        dec_oh[k] = 1'b1;
      end
    end
  end

  always_comb begin
    rdat_sel = '0;
    for (int k = 0; k < NSLAVES; k++) begin
      if (sel_q[k]) rdat_sel = s_rdat[k*DW +: DW];
    end
  end

  // Masking with the registered select makes acks from other slaves invisible.
  assign ack_sel = |(s_ack & sel_q);

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    rdat_d  = '0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m_req) begin
          load = 1'b1;
          if (hit) begin
            state_d = ACCESS;
            cnt_d   = '0;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (TMO > 0) cnt_d = cnt_q + CW'(1);
        // A slave ack in the expiry cycle takes precedence over the timeout.
        if (ack_sel) begin
          state_d = RESP;
          rdat_d  = s_we ? '0 : rdat_sel;
        end else if ((TMO > 0) && (cnt_q == CW'(TMO - 1))) begin
          state_d = RESP;
          err_d   = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
      sel_q   <= '0;
      s_we    <= 1'b0;
      s_adr   <= '0;
      s_wdat  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
      if (load) begin
        sel_q  <= hit ? dec_oh : '0;
        s_we   <= m_we;
        s_adr  <= m_adr;
        s_wdat <= m_wdat;
      end
    end
  end

  assign m_ack  = (state_q == RESP);
  assign m_err  = err_q;
  assign m_rdat = rdat_q;
  assign s_sel  = (state_q == ACCESS) ? sel_q : '0;

endmodule

// File: tb/tb_adrdec_fsm.sv
// Scoreboard bench for adrdec_fsm: the driver queues expected responses, a negedge
// monitor pops and compares them whenever m_ack is seen.
module tb_adrdec_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_req, m_we;
  logic [7:0]  m_adr, m_wdat;
  logic        m_ack, m_err;
  logic [7:0]  m_rdat;
  logic [3:0]  s_sel;
  logic        s_we;
  logic [7:0]  s_adr, s_wdat;
  logic [3:0]  s_ack;
  logic [31:0] s_rdat;

  logic        m_ack2, m_err2, s_we2;
  logic [7:0]  m_rdat2, s_adr2, s_wdat2;
  logic [3:0]  s_sel2;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  typedef struct {
    logic       err;
    logic [7:0] rdat;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  adrdec_fsm dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_adr(m_adr), .m_wdat(m_wdat),
    .m_ack(m_ack), .m_err(m_err), .m_rdat(m_rdat), .s_sel(s_sel), .s_we(s_we),
    .s_adr(s_adr), .s_wdat(s_wdat), .s_ack(s_ack), .s_rdat(s_rdat)
  );

  // Overlapping map: slaves 0 and 1 both at 8'h00.
  adrdec_fsm #(.BASE(32'h3020_0000), .TMO(4)) dut2 (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_adr(m_adr), .m_wdat(m_wdat),
    .m_ack(m_ack2), .m_err(m_err2), .m_rdat(m_rdat2), .s_sel(s_sel2), .s_we(s_we2),
    .s_adr(s_adr2), .s_wdat(s_wdat2), .s_ack(s_ack), .s_rdat(s_rdat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (!rst && m_ack) begin
      if (sb.size() == 0) begin
        check("unexpected_m_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("m_err", 32'(m_err), 32'(e.err));
        check("m_rdat", 32'(m_rdat), 32'(e.rdat));
        check("ack_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // One transfer: slave slv (or -1 for none) pulses s_ack dly cycles after select.
  task automatic xfer(input logic we, input logic [7:0] adr, input logic [7:0] wdat,
                      input int slv, input int dly, input logic [7:0] rd,
                      input logic exp_err, input logic [7:0] exp_rdat, input int exp_lat,
                      input logic [3:0] exp_sel, input logic [3:0] exp_sel2);
    exp_t e;
    bit   done = 0;
    @(negedge clk);
    m_req  = 1'b1;
    m_we   = we;
    m_adr  = adr;
    m_wdat = wdat;
    s_rdat = 32'h4433_2211;
    if (slv >= 0) s_rdat[slv*8 +: 8] = rd;
    e.err = exp_err; e.rdat = exp_rdat; e.cyc = cyc + exp_lat;
    sb.push_back(e);
    for (int i = 1; i <= 40 && !done; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("s_sel", 32'(s_sel), 32'(exp_sel));
        if (exp_sel2 != 4'hF) check("s_sel_overlap", 32'(s_sel2), 32'(exp_sel2));
        if (exp_sel != 4'h0) begin
          check("s_we", 32'(s_we), 32'(we));
          check("s_adr", 32'(s_adr), 32'(adr));
          if (we) check("s_wdat", 32'(s_wdat), 32'(wdat));
        end
        m_adr = 8'h80;
        m_we  = ~we;
      end
      if (m_ack) begin
        check("s_sel_in_resp", 32'(s_sel), 32'd0);
        done = 1;
      end
      s_ack = (!done && slv >= 0 && i == 1 + dly) ? 4'(1 << slv) : 4'b0;
    end
    if (!done) check("m_ack_timeout", 32'd0, 32'd1);
    m_req = 1'b0;
    s_ack = 4'b0;
  endtask

  initial begin
    rst = 1'b1; m_req = 1'b0; m_we = 1'b0; m_adr = 8'h00; m_wdat = 8'h00;
    s_ack = 4'b0; s_rdat = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_m_ack", 32'(m_ack), 32'd0);
    check("rst_m_err", 32'(m_err), 32'd0);
    check("rst_m_rdat", 32'(m_rdat), 32'd0);
    check("rst_s_sel", 32'(s_sel), 32'd0);
    check("rst_s_regs", {15'd0, s_we, s_adr, s_wdat}, 32'd0);
    rst = 1'b0;

    // we adr wdat slv dly rd err rdat lat sel sel2
    xfer(1'b0, 8'h15, 8'h00, 1, 3, 8'hA5, 1'b0, 8'hA5, 5, 4'b0010, 4'h0);
    xfer(1'b1, 8'h02, 8'h5C, 0, 0, 8'h77, 1'b0, 8'h00, 2, 4'b0001, 4'b0001);
    xfer(1'b0, 8'h80, 8'h00, -1, 0, 8'h00, 1'b1, 8'h00, 1, 4'b0000, 4'h0);
    xfer(1'b0, 8'h30, 8'h00, -1, 0, 8'h00, 1'b1, 8'h00, 16, 4'b1000, 4'b1000);
    xfer(1'b0, 8'h3E, 8'h00, 3, 1, 8'h9D, 1'b0, 8'h9D, 3, 4'b1000, 4'hF);
    xfer(1'b0, 8'h07, 8'h00, 0, 0, 8'h3C, 1'b0, 8'h3C, 2, 4'b0001, 4'b0001);
    // Ack in the expiry cycle beats the timeout.
    xfer(1'b0, 8'h21, 8'h00, 2, 14, 8'hC3, 1'b0, 8'hC3, 16, 4'b0100, 4'hF);

    // Foreign ack ignored, then reset aborts the transfer silently.
    @(negedge clk);
    m_req = 1'b1; m_we = 1'b0; m_adr = 8'h25;
    @(negedge clk);
    check("abort_s_sel", 32'(s_sel), 32'b0100);
    m_req = 1'b0;
    s_ack = 4'b0001;
    @(negedge clk);
    s_ack = 4'b0000;
    check("foreign_ack_ignored", {s_sel, 3'b0, m_ack}, {4'b0100, 4'b0});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_s_sel_clr", 32'(s_sel), 32'd0);
    check("abort_s_adr_clr", 32'(s_adr), 32'd0);
    repeat (20) @(negedge clk);
    xfer(1'b0, 8'h11, 8'h00, 1, 0, 8'h5A, 1'b0, 8'h5A, 2, 4'b0010, 4'h0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/adrdec_fsm.md
ADRDEC_FSM -- requirements
Module: adrdec_fsm

Interface
REQ-001 SHALL have parameter NSLAVES, default 4, number of slave ports (legal range 1..8).
REQ-002 SHALL have parameter AW, default 8, address width.
REQ-003 SHALL have parameter DW, default 8, data width.
REQ-004 SHALL have parameter BASE, default {8'h30,8'h20,8'h10,8'h00}, packed NSLAVES*AW base addresses; slave k occupies bits [k*AW +: AW].
REQ-005 SHALL have parameter MASK, default {4{8'hF0}}, packed NSLAVES*AW compare masks; slave k occupies bits [k*AW +: AW].
REQ-006 SHALL have parameter TMO, default 15, slave-ack timeout in cycles; 0 disables the timeout.
REQ-007 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-008 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-009 SHALL have port m_req  input  1  master request; held high until m_ack.
REQ-010 SHALL have port m_we  input  1  master write enable (1 = write).
REQ-011 SHALL have port m_adr  input  AW  master address.
REQ-012 SHALL have port m_wdat  input  DW  master write data.
REQ-013 SHALL have port m_ack  output  1  one-cycle transfer-complete pulse.
REQ-014 SHALL have port m_err  output  1  error flag, qualified by m_ack.
REQ-015 SHALL have port m_rdat  output  DW  read data, qualified by m_ack.
REQ-016 SHALL have port s_sel  output  NSLAVES  one-hot slave select.
REQ-017 SHALL have port s_we, s_adr, s_wdat  output  1/AW/DW  registered copies of m_we/m_adr/m_wdat.
REQ-018 SHALL have port s_ack  input  NSLAVES  per-slave acknowledge.
REQ-019 SHALL have port s_rdat  input  NSLAVES*DW  per-slave read data; slave k in [k*DW +: DW].

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-021 In IDLE with m_req=1 (cycle N), SHALL decode: slave k matches when (m_adr & MASK[k]) == (BASE[k] & MASK[k]); the lowest matching k wins.
REQ-022 On a match SHALL register k, m_we, m_adr, m_wdat and enter ACCESS at N+1, with s_sel[k]=1 and all other s_sel bits 0 throughout ACCESS.
REQ-023 On no match SHALL enter RESP at N+1 with m_ack=1, m_err=1, m_rdat=0; no s_sel bit asserted.
REQ-024 In ACCESS, s_ack[k] of the selected slave SHALL capture s_rdat[k] (reads) and enter RESP next cycle with m_ack=1, m_err=0; minimum latency request-to-m_ack is 2 cycles.
REQ-025 s_ack bits of non-selected slaves SHALL be ignored in all states.
REQ-026 With TMO>0, a counter SHALL clear on ACCESS entry and increment each ACCESS cycle; if TMO cycles pass without s_ack[k], SHALL enter RESP with m_err=1, m_rdat=0 (m_ack at N+TMO+1).
REQ-027 s_ack[k] arriving in the same cycle the counter expires SHALL win (no error).
REQ-028 With TMO=0, ACCESS SHALL wait indefinitely; counter width $clog2(TMO+1), never wraps.
REQ-029 RESP SHALL last exactly one cycle then return to IDLE; m_ack, m_err asserted only in RESP.
REQ-030 m_rdat SHALL be 0 for writes and errors; s_sel SHALL be all-zero outside ACCESS.
REQ-031 Changes on m_req/m_adr outside IDLE SHALL be ignored; a new request is sampled no earlier than the cycle after RESP.

Reset
REQ-032 rst=1 on a clock edge SHALL force IDLE, counter 0, m_ack=0, m_err=0, m_rdat=0, s_sel=0, s_we=0, s_adr=0, s_wdat=0.
REQ-033 rst asserted mid-ACCESS SHALL abort the transfer with no m_ack generated; rst SHALL take priority over every other event.

Verification
REQ-034 Read m_adr=8'h15, slave 1 acks 3 cycles after select with s_rdat=8'hA5 -> s_sel=4'b0010, m_ack=1, m_err=0, m_rdat=8'hA5, one cycle.
REQ-035 Write m_adr=8'h02, m_wdat=8'h5C, slave 0 acks immediately -> s_we=1, s_wdat=8'h5C, m_ack at request+2, m_rdat=0.
REQ-036 m_adr=8'h80 (no match) -> no s_sel, m_ack=1, m_err=1 at request+1.
REQ-037 m_adr=8'h30, slave 3 silent, TMO=15 -> m_ack=1, m_err=1 at request+16; s_sel cleared the same cycle.
REQ-038 Slave 2 selected, slave 0 pulses s_ack -> ignored; rst pulsed mid-ACCESS -> s_sel=0, no m_ack, next request decodes normally.
REQ-039 Overlapping map BASE[0]=BASE[1]=8'h00 -> slave 0 selected.
